// File: rtl/raddr_gen.sv
// raddr_gen -- read-side address sequencer for a single-line pixel buffer.
//
// A rising edge on de_in starts a line read. Up to NUM consecutive addresses
// are issued to the line-buffer RAM, beginning at 'offset' and wrapping at
// NUM. Read order is reversed when 'mirror' is set. A copy of rd_en delayed
// by RD_LAT cycles (de_out) qualifies the RAM read data.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   de_in      in   downstream line enable; a rising edge starts a line read
//   line_ready in   writer has completed a line; sampled at line start
//   offset     in   start pixel 0..NUM-1, latched at line start
//   mirror     in   reverse read order, latched at line start
//   err_clr    in   synchronous clear of the sticky ovf/udf flags
//   rd_en      out  RAM read enable
//   raddr      out  RAM read address
//   de_out     out  rd_en delayed RD_LAT cycles
//   line_done  out  one-cycle pulse at line end
//   ovf        out  sticky: de_in stayed high for more than NUM pixels
//   udf        out  sticky: a line started while line_ready was low
module raddr_gen #(
  parameter  int NUM    = 1280,
  parameter  int RD_LAT = 2,
  localparam int AW     = $clog2(NUM)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          de_in,
  input  logic          line_ready,
  input  logic [AW-1:0] offset,
  input  logic          mirror,
  input  logic          err_clr,
  output logic          rd_en,
  output logic [AW-1:0] raddr,
  output logic          de_out,
  output logic          line_done,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0]   NUM_W = (AW+1)'(NUM);
  localparam logic [AW-1:0] LAST  = AW'(NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     cnt_q;
  logic [AW-1:0]     offset_q;
  logic              mirror_q;
  logic              de_d_q;
  logic              rd_en_q;
  logic [AW-1:0]     raddr_q;
  logic              line_done_q;
  logic              ovf_q;
  logic              udf_q;
  logic [RD_LAT-1:0] dly_q;

  logic              rise;
  logic              start;
  logic [AW-1:0]     sel_off;
  logic              sel_mir;
  logic [AW-1:0]     sel_cnt;
  logic [AW:0]       pos_sum;
  logic [AW:0]       pos_wrap;
  logic [AW-1:0]     pos;
  logic [AW-1:0]     addr_d;
  logic              ovf_set;
  logic              udf_set;

  // At line start the address is formed from the live offset/mirror inputs
  // with cnt=0; afterwards from the latched values with the next count.
  always_comb begin
    rise     = de_in & ~de_d_q;
    start    = (state_q == IDLE) & rise;
    sel_off  = start ? offset : offset_q;
    sel_mir  = start ? mirror : mirror_q;
    sel_cnt  = start ? '0 : cnt_q + 1'b1;
    pos_sum  = {1'b0, sel_off} + {1'b0, sel_cnt};
    pos_wrap = (pos_sum >= NUM_W) ? (pos_sum - NUM_W) : pos_sum;
    pos      = pos_wrap[AW-1:0];
    addr_d   = sel_mir ? (LAST - pos) : pos;
    ovf_set  = (state_q == READ) & de_in & (cnt_q == LAST);
    udf_set  = start & ~line_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      offset_q    <= '0;
      mirror_q    <= 1'b0;
      de_d_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      raddr_q     <= '0;
      line_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      de_d_q      <= de_in;
      line_done_q <= 1'b0;
      // A set event in the same cycle as err_clr wins.
      ovf_q       <= ovf_set | (ovf_q & ~err_clr);
      udf_q       <= udf_set | (udf_q & ~err_clr);
      case (state_q)
        IDLE: begin
          if (rise) begin
            offset_q <= offset;
            mirror_q <= mirror;
            cnt_q    <= '0;
            raddr_q  <= addr_d;
            rd_en_q  <= 1'b1;
            state_q  <= READ;
          end
        end
        READ: begin
          if (de_in) begin
            if (cnt_q != LAST) begin
              cnt_q   <= cnt_q + 1'b1;
              raddr_q <= addr_d;
            end else begin
              // NUM reads already issued; wait for de_in to fall.
              rd_en_q <= 1'b0;
              state_q <= HOLD;
            end
          end else begin
            rd_en_q     <= 1'b0;
            line_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        HOLD: begin
          rd_en_q <= 1'b0;
          if (!de_in) begin
            line_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rd_en delay line matching the RAM read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= rd_en_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign rd_en     = rd_en_q;
  assign raddr     = raddr_q;
  assign de_out    = dly_q[RD_LAT-1];
  assign line_done = line_done_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_raddr_gen.sv
// tb_raddr_gen -- directed testbench for raddr_gen (NUM=1280, RD_LAT=2).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_raddr_gen;

  localparam int NUM = 1280;
  localparam int AW  = 11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          de_in;
  logic          line_ready;
  logic [AW-1:0] offset;
  logic          mirror;
  logic          err_clr;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic          de_out;
  logic          line_done;
  logic          ovf;
  logic          udf;

  int total = 0;
  int bad   = 0;

  // expected-state tracking
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;
  logic d1 = 1'b0;  // expected rd_en one tick ago
  logic d2 = 1'b0;  // expected rd_en two ticks ago
  int   n_de = 0;

  raddr_gen #(.NUM(1280), .RD_LAT(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .de_in      (de_in),
    .line_ready (line_ready),
    .offset     (offset),
    .mirror     (mirror),
    .err_clr    (err_clr),
    .rd_en      (rd_en),
    .raddr      (raddr),
    .de_out     (de_out),
    .line_done  (line_done),
    .ovf        (ovf),
    .udf        (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; check rd_en, de_out (rd_en two ticks back), line_done and flags.
  task automatic step(input string tag, input logic rd_exp, input logic ld_exp);
    logic de_exp;
    @(posedge clk);
    #1;
    de_exp = d2;
    d2 = d1;
    d1 = rd_exp;
    if (de_out === 1'b1) n_de++;
    chk({tag, ".rd_en"},     32'(rd_en),     32'(rd_exp));
    chk({tag, ".de_out"},    32'(de_out),    32'(de_exp));
    chk({tag, ".line_done"}, 32'(line_done), 32'(ld_exp));
    chk({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
    chk({tag, ".udf"},       32'(udf),       32'(exp_udf));
  endtask

  // Hold de_in high for len cycles and check the address sequence, end pulse,
  // de_out length and the held final address (last_addr computed by hand).
  task automatic do_line(input string tag, input int len, input int off, input logic mir,
                         input logic rdy, input logic clr, input int last_addr);
    int exp_a;
    int n_rd;
    offset     = AW'(off);
    mirror     = mir;
    line_ready = rdy;
    err_clr    = clr;
    de_in      = 1'b1;
    exp_a      = mir ? (NUM - 1 - off) : off;
    n_de       = 0;
    n_rd       = (len < NUM) ? len : NUM;
    if (clr) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (!rdy) exp_udf = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == NUM) exp_ovf = 1'b1;
      step(tag, (i < NUM), 1'b0);
      if (i == 0) err_clr = 1'b0;
      if (i < NUM) begin
        chk({tag, ".raddr"}, 32'(raddr), 32'(exp_a));
        if (!mir) exp_a = (exp_a == NUM - 1) ? 0 : exp_a + 1;
        else      exp_a = (exp_a == 0) ? NUM - 1 : exp_a - 1;
      end
      // mid-line changes must not disturb the current line
      if (i == 3) begin
        offset = AW'($urandom_range(NUM - 1, 0));
        mirror = ~mir;
      end
    end
    de_in = 1'b0;
    step(tag, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(tag, 1'b0, 1'b0);
    chk({tag, ".raddr_hold"}, 32'(raddr), 32'(last_addr));
    chk({tag, ".de_out_len"}, 32'(n_de), 32'(n_rd));
  endtask

  initial begin
    rstn       = 1'b0;
    de_in      = 1'b0;
    line_ready = 1'b1;
    offset     = '0;
    mirror     = 1'b0;
    err_clr    = 1'b0;
    #12;
    chk("rst.rd_en",     32'(rd_en),     32'd0);
    chk("rst.raddr",     32'(raddr),     32'd0);
    chk("rst.de_out",    32'(de_out),    32'd0);
    chk("rst.line_done", 32'(line_done), 32'd0);
    chk("rst.ovf",       32'(ovf),       32'd0);
    chk("rst.udf",       32'(udf),       32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    step("idle", 1'b0, 1'b0);
    step("idle", 1'b0, 1'b0);

    do_line("normal",  1280, 0,    1'b0, 1'b1, 1'b0, 1279);
    do_line("offwrap", 1280, 1000, 1'b0, 1'b1, 1'b0, 999);
    do_line("mirror",  1280, 10,   1'b1, 1'b1, 1'b0, 1270);
    do_line("short1",  100,  0,    1'b0, 1'b1, 1'b0, 99);
    do_line("short2",  100,  0,    1'b0, 1'b1, 1'b0, 99);
    do_line("pulse",   1,    5,    1'b0, 1'b1, 1'b0, 5);
    do_line("exact",   1280, 1279, 1'b1, 1'b1, 1'b0, 1);
    do_line("ovf",     1300, 0,    1'b0, 1'b1, 1'b0, 1279);

    err_clr = 1'b1;
    exp_ovf = 1'b0;
    step("ovfclr", 1'b0, 1'b0);
    err_clr = 1'b0;
    step("ovfclr", 1'b0, 1'b0);

    do_line("udf", 50, 0, 1'b0, 1'b0, 1'b0, 49);
    err_clr = 1'b1;
    exp_udf = 1'b0;
    step("udfclr", 1'b0, 1'b0);
    err_clr = 1'b0;
    // clear and set in the same cycle: the set wins
    do_line("setwins", 20, 3, 1'b1, 1'b0, 1'b1, 1257);

    // reset mid-line
    err_clr    = 1'b1;
    exp_udf    = 1'b0;
    step("pre_rst", 1'b0, 1'b0);
    err_clr    = 1'b0;
    offset     = AW'(7);
    mirror     = 1'b0;
    line_ready = 1'b0;
    de_in      = 1'b1;
    exp_udf    = 1'b1;
    for (int k = 0; k < 4; k++) step("midline", 1'b1, 1'b0);
    chk("midline.raddr", 32'(raddr), 32'd10);
    #2 rstn = 1'b0;
    #1;
    chk("arst.rd_en",     32'(rd_en),     32'd0);
    chk("arst.raddr",     32'(raddr),     32'd0);
    chk("arst.de_out",    32'(de_out),    32'd0);
    chk("arst.line_done", 32'(line_done), 32'd0);
    chk("arst.ovf",       32'(ovf),       32'd0);
    chk("arst.udf",       32'(udf),       32'd0);
    d1 = 1'b0;
    d2 = 1'b0;
    exp_udf = 1'b0;
    exp_ovf = 1'b0;
    de_in = 1'b0;
    step("inrst", 1'b0, 1'b0);
    #2 rstn = 1'b1;
    for (int k = 0; k < 3; k++) step("postrst", 1'b0, 1'b0);
    do_line("postline", 4, 0, 1'b0, 1'b1, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
